// File: rtl/inst_fetch_queue_if.sv
`timescale 1ns/1ps
// Fetch-queue signal bundle: memory request/response, commit redirect and decoder handshake.
// The master side is the fetch queue; the slave side is the memory controller, commit and decode.
interface inst_fetch_queue_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_ready_in;
  logic        pred_taken_out;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  flush_in, flush_pc_in,
    output inst_valid_out, inst_out, pc_out, pred_taken_out,
    input  inst_ready_in
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output flush_in, flush_pc_in,
    input  inst_valid_out, inst_out, pc_out, pred_taken_out,
    output inst_ready_in
  );
endinterface

// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
// Fetch queue: one-outstanding word reads into an {inst,pc} FIFO feeding decode; PREDECODE_JAL_EN adds JAL prediction.
// Latency: head valid 1 cycle after mem_resp_valid. Backpressure: no request unless a FIFO slot is free; rdy_in low freezes all.
module inst_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               rdy_in,
  inst_fetch_queue_if.master fq
);

  localparam int unsigned   PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [6:0]    OP_JALR = 7'b1100111;
`ifdef PREDECODE_JAL_EN
  localparam logic [6:0]    OP_JAL  = 7'b1101111;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        fifo_q [QUEUE_DEPTH];

  logic          flush;
  logic          resp_take;
  logic          push;
  logic          pop;
  logic          is_jalr;
  logic          push_pred;
  logic [31:0]   pc_after;
  entry_t        push_ent;
  entry_t        head_ent;

  assign flush     = rdy_in && fq.flush_in;
  assign resp_take = (state_q == S_WAIT) && fq.mem_resp_valid;
  assign push      = rdy_in && !fq.flush_in && resp_take;
  assign pop       = rdy_in && !fq.flush_in && fq.inst_ready_in && (count_q != '0);
  assign is_jalr   = (fq.mem_resp_data[6:0] == OP_JALR);

`ifdef PREDECODE_JAL_EN
  logic [31:0] jal_imm;
  assign jal_imm   = {{11{fq.mem_resp_data[31]}}, fq.mem_resp_data[31], fq.mem_resp_data[19:12],
                      fq.mem_resp_data[20], fq.mem_resp_data[30:21], 1'b0};
  assign push_pred = (fq.mem_resp_data[6:0] == OP_JAL);
  // A halfword-aligned target still fetches the containing word.
  assign pc_after  = push_pred ? ((pc_q + jal_imm) & 32'hFFFF_FFFC) : (pc_q + 32'd4);
`else
  assign push_pred = 1'b0;
  assign pc_after  = pc_q + 32'd4;
`endif

  assign push_ent = '{inst: fq.mem_resp_data, pc: pc_q, pred: push_pred};
  assign head_ent = fifo_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (rdy_in) begin
      if (fq.flush_in) begin
        pc_d = fq.flush_pc_in & 32'hFFFF_FFFC;
        // Any fetch still owed by memory must be swallowed before a new request goes out.
        if ((state_q == S_WAIT || state_q == S_DROP) && !fq.mem_resp_valid) begin
          state_d = S_DROP;
        end else if (state_q == S_REQ && fq.mem_req_ready) begin
          state_d = S_DROP;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (count_q < DEPTH_C) begin
              state_d = S_REQ;
            end
          end
          S_REQ: begin
            if (fq.mem_req_ready) begin
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (fq.mem_resp_valid) begin
              pc_d    = pc_after;
              state_d = is_jalr ? S_HALT : S_IDLE;
            end
          end
          S_DROP: begin
            if (fq.mem_resp_valid) begin
              state_d = S_IDLE;
            end
          end
          S_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_ent;
    end
  end

  assign fq.mem_req_valid  = (state_q == S_REQ);
  assign fq.mem_req_addr   = fq.mem_req_valid ? pc_q : 32'h0;
  assign fq.inst_valid_out = (count_q != '0);
  assign fq.inst_out       = fq.inst_valid_out ? head_ent.inst : 32'h0;
  assign fq.pc_out         = fq.inst_valid_out ? head_ent.pc : 32'h0;
  assign fq.pred_taken_out = fq.inst_valid_out && head_ent.pred;

endmodule

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps
// Bench for inst_fetch_queue: queue-based reference model checked every cycle plus directed scenarios.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
`ifdef PREDECODE_JAL_EN
  localparam logic [31:0] JAL_NEXT = 32'h20;
  localparam logic        JAL_PRED = 1'b1;
`else
  localparam logic [31:0] JAL_NEXT = 32'h14;
  localparam logic        JAL_PRED = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic rdy_in = 1'b1;
  always #5 clk_in = ~clk_in;

  inst_fetch_queue_if bus();
  inst_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .rdy_in (rdy_in),
    .fq     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected queue contents, next fetch address, halt flag.
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic        q_pred[$];
  logic [31:0] m_pc;
  bit          m_halt;

  // Memory responder state.
  bit          pend_vld, pend_stale, cur_stale;
  int          pend_cnt, resp_delay;
  logic [31:0] pend_addr, pend_data, cur_addr;
  bit          resp_override;
  logic [31:0] override_data;
  logic [31:0] imem [logic [31:0]];

  logic [31:0] acc_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  bit          prev_rdy;
  logic        prev_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h0000_0013;
  endfunction

  function automatic logic jal_pred(input logic [31:0] inst);
`ifdef PREDECODE_JAL_EN
    return inst[6:0] == 7'b1101111;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] inst);
    logic [20:0] j;
    j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    if (jal_pred(inst)) return (pc + {{11{j[20]}}, j}) & 32'hFFFF_FFFC;
    return pc + 32'd4;
  endfunction

  task automatic clear_logs();
    acc_log.delete();
    pop_pc.delete();
    pop_inst.delete();
  endtask

  task automatic accept(input bit stale);
    acc_log.push_back(bus.mem_req_addr);
    pend_vld   = 1'b1;
    pend_stale = stale;
    pend_cnt   = resp_delay;
    pend_addr  = bus.mem_req_addr;
    pend_data  = resp_override ? override_data : mem_word(bus.mem_req_addr);
  endtask

  // Runs at the falling edge: check outputs, then advance the model to what the next rising edge does.
  task automatic monitor_step();
    bit pop_now;
    chk("head_valid", bus.inst_valid_out, q_pc.size() != 0);
    if (q_pc.size() != 0) begin
      chk("head_inst", bus.inst_out, q_inst[0]);
      chk("head_pc", bus.pc_out, q_pc[0]);
      chk("head_pred", bus.pred_taken_out, q_pred[0]);
    end
    if (bus.mem_req_valid) begin
      chk("req_addr", bus.mem_req_addr, m_pc);
      chk("req_single_outstanding", pend_vld, 0);
      chk("req_not_halted", m_halt, 0);
      chk("req_has_space", q_pc.size() < DEPTH, 1);
    end
    if (!prev_rdy) chk("req_valid_held", bus.mem_req_valid, prev_req);
    prev_rdy = rdy_in;
    prev_req = bus.mem_req_valid;
    if (!rdy_in) return;
    if (bus.flush_in) begin
      q_inst.delete();
      q_pc.delete();
      q_pred.delete();
      m_pc   = bus.flush_pc_in & 32'hFFFF_FFFC;
      m_halt = 1'b0;
      if (pend_vld) pend_stale = 1'b1;
      if (bus.mem_req_valid && bus.mem_req_ready) accept(1'b1);
    end else begin
      pop_now = bus.inst_ready_in && (q_pc.size() != 0);
      if (pop_now) begin
        pop_pc.push_back(bus.pc_out);
        pop_inst.push_back(bus.inst_out);
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
        void'(q_pred.pop_front());
      end
      if (bus.mem_resp_valid && !cur_stale) begin
        q_inst.push_back(bus.mem_resp_data);
        q_pc.push_back(cur_addr);
        q_pred.push_back(jal_pred(bus.mem_resp_data));
        m_pc = next_pc(cur_addr, bus.mem_resp_data);
        if (bus.mem_resp_data[6:0] == 7'b1100111) m_halt = 1'b1;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) accept(1'b0);
    end
  endtask

  task automatic responder_step();
    bus.mem_resp_valid = 1'b0;
    if (rdy_in && pend_vld) begin
      if (pend_cnt == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = pend_data;
        cur_addr           = pend_addr;
        cur_stale          = pend_stale;
        pend_vld           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_n) monitor_step();
      @(posedge clk_in);
      #2;
      responder_step();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] p);
    bus.flush_in    = 1'b1;
    bus.flush_pc_in = p;
    cyc(1);
    bus.flush_in    = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc_log.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, acc_log.size() >= n, 1);
  endtask

  task automatic wait_pop(input int n, input int budget, input string name);
    int k = 0;
    while (pop_pc.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, pop_pc.size() >= n, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] snap_pc, base_n;
    logic        snap_vld, snap_req;
    int          dead_cnt;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    bus.flush_in       = 1'b0;
    bus.flush_pc_in    = 32'h0;
    bus.inst_ready_in  = 1'b0;
    resp_delay = 0;  resp_override = 1'b0;  override_data = 32'h0;
    pend_vld = 1'b0; pend_stale = 1'b0; cur_stale = 1'b0; pend_cnt = 0;
    pend_addr = 32'h0; pend_data = 32'h0; cur_addr = 32'h0;
    m_pc = 32'h0; m_halt = 1'b0; prev_rdy = 1'b1; prev_req = 1'b0;

    #1 rst_n = 1'b0;
    #11;
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_inst_valid", bus.inst_valid_out, 0);
    chk("rst_inst", bus.inst_out, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_pred", bus.pred_taken_out, 0);

    // Sequential fetch from reset.
    cyc(1);
    clear_logs();
    bus.inst_ready_in = 1'b1;
    rst_n = 1'b1;
    wait_pop(4, 100, "t1_pops");
    for (int i = 0; i < 4; i++) begin
      chk("t1_req_addr", i < acc_log.size() ? acc_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
      chk("t1_pop_pc", i < pop_pc.size() ? pop_pc[i] : 32'hFFFF_FFFF, 32'(4 * i));
      chk("t1_pop_inst", i < pop_inst.size() ? pop_inst[i] : 32'hFFFF_FFFF, 32'h13);
    end

    // Decoder stalled: fills to depth, then one pop frees exactly one request.
    bus.inst_ready_in = 1'b0;
    do_flush(32'h40);
    clear_logs();
    cyc(60);
    chk("t2_req_count_full", acc_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_req_addr", i < acc_log.size() ? acc_log[i] : 32'hFFFF_FFFF, 32'h40 + 32'(4 * i));
    chk("t2_req_idle_full", bus.mem_req_valid, 0);
    chk("t2_head_pc", bus.pc_out, 32'h40);
    bus.inst_ready_in = 1'b1;
    cyc(1);
    bus.inst_ready_in = 1'b0;
    cyc(40);
    chk("t2_req_count_after_pop", acc_log.size(), 5);
    chk("t2_refill_addr", acc_log.size() > 4 ? acc_log[4] : 32'hFFFF_FFFF, 32'h50);
    chk("t2_head_after_pop", bus.pc_out, 32'h44);

    // JALR halts fetch until a flush.
    imem[32'h8] = 32'h0000_80E7;
    bus.inst_ready_in = 1'b1;
    do_flush(32'h0);
    clear_logs();
    cyc(40);
    chk("t3_req_count", acc_log.size(), 3);
    chk("t3_last_addr", acc_log.size() > 2 ? acc_log[2] : 32'hFFFF_FFFF, 32'h8);
    chk("t3_halted", bus.mem_req_valid, 0);
    chk("t3_jalr_popped", pop_inst.size() > 2 ? pop_inst[2] : 32'hFFFF_FFFF, 32'h0000_80E7);
    do_flush(32'h100);
    imem.delete(32'h8);
    chk("t3_queue_empty", bus.inst_valid_out, 0);
    clear_logs();
    wait_acc(1, 20, "t3_restart");
    chk("t3_redirect_addr", acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF, 32'h100);

    // Flush during WAIT; the late response must be dropped.
    resp_delay = 1;
    resp_override = 1'b1;
    override_data = 32'hDEAD_BEEF;
    base_n = acc_log.size();
    wait_acc(int'(base_n) + 1, 20, "t4_req_seen");
    resp_override = 1'b0;
    do_flush(32'h200);
    resp_delay = 0;
    clear_logs();
    wait_pop(2, 60, "t4_pops");
    chk("t4_redirect_addr", acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF, 32'h200);
    chk("t4_first_pop_pc", pop_pc.size() > 0 ? pop_pc[0] : 32'hFFFF_FFFF, 32'h200);
    chk("t4_first_pop_inst", pop_inst.size() > 0 ? pop_inst[0] : 32'hFFFF_FFFF, 32'h13);
    dead_cnt = 0;
    foreach (pop_inst[i]) if (pop_inst[i] == 32'hDEAD_BEEF) dead_cnt++;
    chk("t4_stale_not_enqueued", dead_cnt, 0);

    // JAL at 0x10: predicted redirect only with predecode enabled.
    bus.inst_ready_in = 1'b0;
    imem[32'h10] = 32'h0100_006F;
    do_flush(32'h10);
    clear_logs();
    wait_acc(2, 40, "t5_reqs");
    chk("t5_jal_addr", acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF, 32'h10);
    chk("t5_after_jal", acc_log.size() > 1 ? acc_log[1] : 32'hFFFF_FFFF, JAL_NEXT);
    chk("t5_head_pc", bus.pc_out, 32'h10);
    chk("t5_head_inst", bus.inst_out, 32'h0100_006F);
    chk("t5_pred", bus.pred_taken_out, JAL_PRED);
    imem.delete(32'h10);

    // Full queue streaming with a 3-cycle freeze.
    do_flush(32'h400);
    clear_logs();
    cyc(60);
    chk("t6_full_count", acc_log.size(), 4);
    chk("t6_full_valid", bus.inst_valid_out, 1);
    bus.inst_ready_in = 1'b1;
    cyc(7);
    rdy_in   = 1'b0;
    snap_pc  = bus.pc_out;
    snap_vld = bus.inst_valid_out;
    snap_req = bus.mem_req_valid;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t6_frozen_pc", bus.pc_out, snap_pc);
      chk("t6_frozen_valid", bus.inst_valid_out, snap_vld);
      chk("t6_frozen_req", bus.mem_req_valid, snap_req);
    end
    rdy_in = 1'b1;
    cyc(40);
    bus.inst_ready_in = 1'b0;
    chk("t6_pop_count", pop_pc.size() >= 8, 1);
    foreach (pop_pc[i]) chk("t6_pop_order", pop_pc[i], 32'h400 + 32'(4 * i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
